mem_arb: RTL and testbench

Two-requester memory arbiter that shares one memory port between instruction fetch (IF) and the load/store unit (MEM). It takes one outstanding request at a time and issues it downstream through a valid/ready request channel. It waits for the single response and returns it to the requester that owns the transaction. It sits between `if_stage`/`mem_stage` and the shared RAM model, replacing the dedicated instruction and data read ports once the core moves to multi-cycle memory.

---
 rtl/mem_arb.sv | 153 +++++++++++++++
 tb/tb_mem_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-requester (IF, MEM) arbiter sharing one valid/ready memory port.
// Ports: clk, rst (async high); if_req_*/if_rsp_*, mem_req_*/mem_rsp_* upstream;
//        ram_req_*/ram_rsp_* downstream; arb_err sticky protocol-violation flag.
// Macro MEM_ARB_RR_EN: round-robin arbitration; undefined = MEM fixed priority.
module mem_arb #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            mem_req_valid,
  output logic            mem_req_ready,
  input  logic [AW-1:0]   mem_addr,
  input  logic            mem_wen,
  input  logic [DW-1:0]   mem_wdata,
  input  logic [DW/8-1:0] mem_wstrb,
  output logic            mem_rsp_valid,
  output logic [DW-1:0]   mem_rdata,
  output logic            ram_req_valid,
  input  logic            ram_req_ready,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_wen,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wstrb,
  input  logic            ram_rsp_valid,
  input  logic [DW-1:0]   ram_rdata,
  output logic            arb_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          owner;
  logic [DW-1:0] rdata_q;
  logic          idle;
  logic          prio_mem;
  logic          grant_if;
  logic          grant_mem;
  logic          hs;

  // Ready is suppressed while reset is held so every output reads 0.
  assign idle = (state == IDLE) && !rst;

`ifdef MEM_ARB_RR_EN
  // last_mem = 1 when MEM won the previous grant; reset favours MEM.
  logic last_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mem <= 1'b0;
    end else if (hs) begin
      last_mem <= grant_mem;
    end
  end

  assign prio_mem = !last_mem;
`else
  assign prio_mem = 1'b1;
`endif

  assign grant_mem = idle && mem_req_valid &&
                     (prio_mem || !if_req_valid);
  assign grant_if  = idle && if_req_valid && !grant_mem;
  assign hs        = grant_if || grant_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (hs) state_nx = ISSUE;
      ISSUE: if (ram_req_ready) state_nx = WAIT;
      WAIT:  if (ram_rsp_valid) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = grant_if;
    mem_req_ready = grant_mem;
    ram_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    mem_rsp_valid = 1'b0;
    if_rdata      = '0;
    mem_rdata     = '0;
    unique case (state)
      ISSUE: ram_req_valid = 1'b1;
      RESP: begin
        if (owner) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = rdata_q;
        end else begin
          if_rsp_valid  = 1'b1;
          if_rdata      = rdata_q;
        end
      end
      default: ;
    endcase
  end

  // Request fields are captured once and held through ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wen   <= 1'b0;
      ram_wdata <= '0;
      ram_wstrb <= '0;
      owner     <= 1'b0;
    end else if (hs) begin
      owner     <= grant_mem;
      ram_addr  <= grant_mem ? mem_addr : if_addr;
      ram_wen   <= grant_mem && mem_wen;
      ram_wdata <= grant_mem ? mem_wdata : '0;
      ram_wstrb <= grant_mem ? mem_wstrb : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state == WAIT && ram_rsp_valid) begin
      rdata_q <= ram_wen ? '0 : ram_rdata;
    end
  end

  // A response outside WAIT has no owner; flag it and drop it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_err <= 1'b0;
    end else if (ram_rsp_valid && state != WAIT) begin
      arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb.
// Drives IF/MEM requests and a hand-sequenced RAM, checks with assertions.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [63:0] if_rdata;
  logic        mem_req_valid = 1'b0;
  logic        mem_req_ready;
  logic [63:0] mem_addr = '0;
  logic        mem_wen = 1'b0;
  logic [63:0] mem_wdata = '0;
  logic [7:0]  mem_wstrb = '0;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        ram_req_valid;
  logic        ram_req_ready = 1'b0;
  logic [63:0] ram_addr;
  logic        ram_wen;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_wstrb;
  logic        ram_rsp_valid = 1'b0;
  logic [63:0] ram_rdata = '0;
  logic        arb_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
    .if_rdata(if_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .ram_req_valid(ram_req_valid), .ram_req_ready(ram_req_ready),
    .ram_addr(ram_addr), .ram_wen(ram_wen),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_rsp_valid(ram_rsp_valid), .ram_rdata(ram_rdata),
    .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE; caller has already driven requests.
  task automatic txn(input string tag, input logic is_mem,
                     input logic [63:0] addr, input logic wen,
                     input logic [63:0] wdata, input logic [7:0] wstrb,
                     input logic [63:0] rd, input int stall);
    int t0;
    #1;
    t0 = cyc;
    chk({tag, ".if_ready"}, 64'(if_req_ready), 64'(!is_mem));
    chk({tag, ".mem_ready"}, 64'(mem_req_ready), 64'(is_mem));
    tick();
    for (int i = 0; i < stall; i++) begin
      ram_req_ready = 1'b0;
      #1;
      chk({tag, ".stall_valid"}, 64'(ram_req_valid), 64'd1);
      chk({tag, ".stall_addr"}, ram_addr, addr);
      chk({tag, ".stall_wen"}, 64'(ram_wen), 64'(wen));
      chk({tag, ".stall_rdy"}, 64'(if_req_ready | mem_req_ready), 64'd0);
      tick();
    end
    ram_req_ready = 1'b1;
    #1;
    chk({tag, ".ram_valid"}, 64'(ram_req_valid), 64'd1);
    chk({tag, ".ram_addr"}, ram_addr, addr);
    chk({tag, ".ram_wen"}, 64'(ram_wen), 64'(wen));
    chk({tag, ".ram_wstrb"}, 64'(ram_wstrb), 64'(wstrb));
    if (is_mem) chk({tag, ".ram_wdata"}, ram_wdata, wdata);
    chk({tag, ".issue_rdy"}, 64'(if_req_ready | mem_req_ready), 64'd0);
    tick();
    ram_req_ready = 1'b0;
    ram_rsp_valid = 1'b1;
    ram_rdata = rd;
    #1;
    chk({tag, ".wait_valid"}, 64'(ram_req_valid), 64'd0);
    tick();
    ram_rsp_valid = 1'b0;
    ram_rdata = '0;
    #1;
    chk({tag, ".if_rsp"}, 64'(if_rsp_valid), 64'(!is_mem));
    chk({tag, ".mem_rsp"}, 64'(mem_rsp_valid), 64'(is_mem));
    chk({tag, ".rdata"}, is_mem ? mem_rdata : if_rdata,
        wen ? 64'd0 : rd);
    chk({tag, ".latency"}, 64'(cyc - t0), 64'(3 + stall));
    chk({tag, ".resp_rdy"}, 64'(if_req_ready | mem_req_ready), 64'd0);
    tick();
    chk({tag, ".rsp_clr"}, 64'(if_rsp_valid | mem_rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #2;
    chk("rst.ram_valid", 64'(ram_req_valid), 64'd0);
    chk("rst.ram_addr", ram_addr, 64'd0);
    chk("rst.rsp", 64'(if_rsp_valid | mem_rsp_valid), 64'd0);
    chk("rst.err", 64'(arb_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // IF read
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0000;
    txn("ifrd", 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00,
        64'h0000_0013_0000_0093, 0);
    if_req_valid = 1'b0;

    // MEM write
    mem_req_valid = 1'b1;
    mem_addr = 64'h8000_1000;
    mem_wen = 1'b1;
    mem_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    mem_wstrb = 8'h0F;
    txn("memwr", 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D,
        8'h0F, 64'h1111_2222_3333_4444, 0);
    mem_req_valid = 1'b0;
    mem_wen = 1'b0;
    mem_wstrb = 8'h00;

    // Conflicts from a fresh pointer
    do_reset();
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0100;
    mem_req_valid = 1'b1;
    mem_addr = 64'h8000_2000;
    mem_wdata = 64'h0;
`ifdef MEM_ARB_RR_EN
    txn("rr0", 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'h00, 64'hA0, 0);
    txn("rr1", 1'b0, 64'h8000_0100, 1'b0, 64'd0, 8'h00, 64'hA1, 0);
    txn("rr2", 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'h00, 64'hA2, 0);
    txn("rr3", 1'b0, 64'h8000_0100, 1'b0, 64'd0, 8'h00, 64'hA3, 0);
`else
    txn("fp0", 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'h00, 64'hA0, 0);
    txn("fp1", 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'h00, 64'hA1, 0);
    txn("fp2", 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'h00, 64'hA2, 0);
    txn("fp3", 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'h00, 64'hA3, 0);
`endif
    if_req_valid = 1'b0;
    mem_req_valid = 1'b0;

    // Downstream stall
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0040;
    txn("stall", 1'b0, 64'h8000_0040, 1'b0, 64'd0, 8'h00,
        64'h0BAD_F00D_1234_5678, 5);
    if_req_valid = 1'b0;

    // Spurious response in IDLE
    ram_rsp_valid = 1'b1;
    ram_rdata = 64'hFFFF;
    tick();
    ram_rsp_valid = 1'b0;
    ram_rdata = '0;
    #1;
    chk("spur.err", 64'(arb_err), 64'd1);
    chk("spur.rsp", 64'(if_rsp_valid | mem_rsp_valid), 64'd0);
    mem_req_valid = 1'b1;
    mem_addr = 64'h8000_3000;
    txn("spur_txn", 1'b1, 64'h8000_3000, 1'b0, 64'd0, 8'h00,
        64'h5555_AAAA_5555_AAAA, 0);
    mem_req_valid = 1'b0;
    chk("spur.sticky", 64'(arb_err), 64'd1);

    // Async reset while waiting for the RAM
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0800;
    tick();
    ram_req_ready = 1'b1;
    tick();
    ram_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.ram_addr", ram_addr, 64'd0);
    chk("arst.ram_valid", 64'(ram_req_valid), 64'd0);
    chk("arst.err", 64'(arb_err), 64'd0);
    chk("arst.if_ready", 64'(if_req_ready), 64'd0);
    chk("arst.rsp", 64'(if_rsp_valid | mem_rsp_valid), 64'd0);
    if_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0C00;
    txn("arst_txn", 1'b0, 64'h8000_0C00, 1'b0, 64'd0, 8'h00,
        64'h0000_0000_0000_0013, 0);
    if_req_valid = 1'b0;
    chk("arst.err_after", 64'(arb_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
